// File: rtl/fetch_pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen_pkg
// Description : Shared types and constants for the fetch-stage PC generator.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pc_gen_pkg;

   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   // Redirect targets are word-aligned by clearing the two low bits.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return {pc[PC_W-1:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_gen_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sat_cnt
// Description : Saturating up-counter with enable; sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // Count up on enable until all-ones, then hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen
// Description : Fetch PC generator: sequential/predicted advance, redirect on
//               mispredict (immediate or deferred while stalled), and
//               saturating branch / mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
   import fetch_pc_gen_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             f_allow_in,
   input  logic [31:0]      f_spec_pred_pc,
   input  logic             e_stage_valid,
   input  logic             e_stage_is_jump_instr,
   input  logic             e_pred_correct,
   input  logic [31:0]      e_redirect_pc,
   output logic [31:0]      F_pc,
   output logic [31:0]      f_default_pc,
   output logic             f_valid,
   output logic             f_flush_fd,
   output logic [CNT_W-1:0] cnt_branch,
   output logic [CNT_W-1:0] cnt_mispred
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   w_pc_nxt;
   logic              r_valid;
   logic              w_valid_nxt;
   logic [PC_W-1:0]   r_pend_pc;
   logic [PC_W-1:0]   w_pend_nxt;

   logic              w_resolved;
   logic              w_mispredict;
   logic              w_count_en;
   logic [PC_W-1:0]   w_redir_pc;

   assign w_resolved   = e_stage_valid & e_stage_is_jump_instr;
   assign w_mispredict = w_resolved & ~e_pred_correct;
   assign w_redir_pc   = align_pc(e_redirect_pc);
   // The execute stage is empty during the boot cycle, so nothing counts there.
   assign w_count_en   = (r_state != ST_BOOT);

   // State, fetch PC, valid flag and deferred redirect registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_BOOT;
         r_pc      <= RESET_PC;
         r_valid   <= 1'b0;
         r_pend_pc <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_valid   <= w_valid_nxt;
         r_pend_pc <= w_pend_nxt;
      end
   end

   // Next-state and next-PC selection.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_valid_nxt = r_valid;
      w_pend_nxt  = r_pend_pc;
      case (r_state)
         ST_BOOT: begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = RESET_PC;
            w_valid_nxt = 1'b1;
         end
         ST_RUN: begin
            w_valid_nxt = 1'b1;
            if (w_mispredict) begin
               if (f_allow_in) begin
                  w_pc_nxt = w_redir_pc;
               end else begin
                  // Stalled: remember the target and mark fetch as wrong-path.
                  w_pend_nxt  = w_redir_pc;
                  w_valid_nxt = 1'b0;
                  w_state_nxt = ST_PEND;
               end
            end else if (f_allow_in) begin
               w_pc_nxt = f_spec_pred_pc;
            end
         end
         ST_PEND: begin
            w_valid_nxt = 1'b0;
            if (f_allow_in) begin
               // A redirect arriving in the release cycle is newer than pend_pc.
               w_pc_nxt    = w_mispredict ? w_redir_pc : r_pend_pc;
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_RUN;
            end else if (w_mispredict) begin
               w_pend_nxt = w_redir_pc;
            end
         end
         default: begin
            w_state_nxt = ST_BOOT;
            w_pc_nxt    = RESET_PC;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   assign F_pc         = r_pc;
   assign f_valid      = r_valid;
   assign f_default_pc = r_pc + 32'd4;
   assign f_flush_fd   = w_mispredict;

   sat_cnt #(.CNT_W(CNT_W)) u_cnt_branch (
      .clk     (clk),
      .rst_n   (rst),
      .i_inc   (w_count_en & w_resolved),
      .o_count (cnt_branch)
   );

   sat_cnt #(.CNT_W(CNT_W)) u_cnt_mispred (
      .clk     (clk),
      .rst_n   (rst),
      .i_inc   (w_count_en & w_mispredict),
      .o_count (cnt_mispred)
   );

endmodule
`default_nettype wire

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage PC generator. It sits directly upstream of the PC predictor. Each cycle it presents the current fetch address and its sequential successor, advances to the predictor's speculative next PC, and redirects to the execute-stage resolved PC on a misprediction. A small state machine covers the boot cycle and redirects that arrive while fetch is stalled. Two saturating performance counters track resolved control-flow instructions and mispredictions.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- f_allow_in  in  1  fetch register may advance this cycle.
- f_spec_pred_pc  in  32  predictor's speculative next PC for F_pc.
- e_stage_valid  in  1  execute stage holds a valid instruction.
- e_stage_is_jump_instr  in  1  that instruction is a branch, jal or jalr.
- e_pred_correct  in  1  prediction made at fetch matched the resolved outcome.
- e_redirect_pc  in  32  resolved correct next PC.
- F_pc  out  32  current fetch address (registered).
- f_default_pc  out  32  F_pc + 4, modulo 2^32.
- f_valid  out  1  F_pc is on the correct path and may be fetched (registered).
- f_flush_fd  out  1  kill instructions in fetch/decode and decode/execute (combinational).
- cnt_branch  out  CNT_W  resolved control-flow instruction count.
- cnt_mispred  out  CNT_W  misprediction count.

## Operation
- mispredict = e_stage_valid & e_stage_is_jump_instr & ~e_pred_correct.
- f_flush_fd = mispredict, in the same cycle, independent of f_allow_in and state.
- Loaded redirect addresses have bits [1:0] cleared. The predicted PC is taken as-is.
- Reset values: state = BOOT, F_pc = RESET_PC, f_valid = 0, pend_pc = 0, both counters = 0.
- BOOT: lasts one cycle. Next state is RUN with f_valid = 1 and F_pc = RESET_PC. A mispredict in BOOT is ignored, because the execute stage is empty.
- RUN:
  - mispredict & f_allow_in: F_pc <= e_redirect_pc; f_valid stays 1.
  - mispredict & ~f_allow_in: pend_pc <= e_redirect_pc; f_valid <= 0; go to PEND.
  - no mispredict & f_allow_in: F_pc <= f_spec_pred_pc.
  - otherwise: hold.
- PEND: f_valid = 0, and F_pc holds the wrong-path address.
  - f_allow_in: F_pc <= pend_pc (or e_redirect_pc if a mispredict occurs in the same cycle); f_valid <= 1; go to RUN.
  - mispredict & ~f_allow_in: pend_pc <= e_redirect_pc (the newer redirect wins); stay in PEND.
- Counters:
  - cnt_branch += 1 when e_stage_valid & e_stage_is_jump_instr.
  - cnt_mispred += 1 on mispredict.
  - Both saturate at all-ones and never wrap. They count in every state except BOOT.
- Reset asserted mid-operation: all state returns to reset values immediately and asynchronously. Any pending redirect is discarded.

## Timing
- Redirect latency: a mispredict with f_allow_in in cycle t gives F_pc = redirect in cycle t+1.
- Stalled redirect: F_pc = redirect in the cycle after the first f_allow_in seen in PEND.
- Sequential advance: F_pc takes f_spec_pred_pc one cycle after each f_allow_in.
- First valid fetch occurs at the second rising edge after reset release.
- Counter values are visible in the cycle after the qualifying event.
- f_default_pc and f_flush_fd have zero-cycle latency. All other outputs are registered.

## Structure
- Shared package: state enum {BOOT, RUN, PEND}, RESET_PC default, and the PC width constant 32.
- One sub-module, sat_cnt: a CNT_W-bit saturating incrementer with active-low async reset and an inc enable, instantiated twice.
- The next-PC mux and state machine live in the top module.

## Test plan
- Reset release: F_pc = 32'h8000_0000 throughout. f_valid = 0 for one cycle, then 1. f_default_pc = 32'h8000_0004.
- Predicted path: f_allow_in = 1 with f_spec_pred_pc = 0x80000010. Next cycle F_pc = 0x80000010. With f_allow_in = 0, F_pc holds.
- Mispredict with advance: mispredict, f_allow_in = 1, e_redirect_pc = 0x80000103. f_flush_fd = 1 the same cycle. Next cycle F_pc = 0x80000100 with f_valid = 1. cnt_mispred = 1 and cnt_branch = 1.
- Stalled redirect: mispredict with f_allow_in = 0 for 3 cycles gives f_valid = 0. A second mispredict to 0x80000200 overwrites the first. One cycle after f_allow_in = 1, F_pc = 0x80000200 and f_valid = 1.
- Saturation (CNT_W = 4): 20 mispredicts give cnt_mispred = 4'hF and cnt_branch = 4'hF, with no wrap.
- Reset during PEND: drive rst low. F_pc = RESET_PC, f_valid = 0, and counters = 0 without waiting for a clock edge. After release, the pending redirect is not applied.
